cam_emulator: RTL and testbench
===============================

CAM_EMULATOR -- requirements
Module: cam_emulator

Interface
REQ-001 SHALL have parameter H_ACTIVE, 640, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, 480, active lines per frame.
REQ-003 SHALL have parameter H_BLANK, 144, blank pixel periods per line (2 byte slots each).
REQ-004 SHALL have parameter VSYNC_LINES, 3, lines with vsync high.
REQ-005 SHALL have parameter VBP_LINES, 17, blank lines after vsync.
REQ-006 SHALL have parameter VFP_LINES, 10, blank lines after last active line.
REQ-007 SHALL have port clk  input  1  system clock; single clock domain.
REQ-008 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-009 SHALL have port enable  input  1  run frames while high.
REQ-010 SHALL have port pattern_sel  input  2  0 ramp, 1 bars, 2 solid, 3 moving box.
REQ-011 SHALL have port fill_y  input  8  luminance for solid pattern and box background.
REQ-012 SHALL have port pclk  output  1  emulated camera pixel clock, clk/2.
REQ-013 SHALL have port vsync  output  1  frame sync, active high.
REQ-014 SHALL have port href  output  1  line-valid, high during active bytes.
REQ-015 SHALL have port byte_out  output  8  camera data bus, YUYV byte stream.
REQ-016 SHALL have port frame_done  output  1  one-clk pulse after last VFP line.

Function
REQ-017 pclk SHALL toggle every clk while state is not IDLE; held 0 in IDLE.
REQ-018 href, vsync, byte_out SHALL change only on the clk edge where pclk goes 1->0; stable across pclk rising edge.
REQ-019 one byte slot = one pclk period; line length = 2*(H_ACTIVE+H_BLANK) slots (1568 default).
REQ-020 FSM states: IDLE, VSYNC, VBP, ACTIVE, VFP; IDLE->VSYNC when enable=1 at a slot boundary.
REQ-021 VSYNC lasts VSYNC_LINES lines, VBP lasts VBP_LINES, ACTIVE lasts V_ACTIVE, VFP lasts VFP_LINES.
REQ-022 in ACTIVE, href=1 for first 2*H_ACTIVE slots of each line, 0 for remaining 2*H_BLANK slots.
REQ-023 active byte pairs per pixel x: even slot = Y, odd slot = 0x80.
REQ-024 Y for pattern 0 = x[9:2] (ramp, saturating 8 bits via truncation of x>>2).
REQ-025 Y for pattern 1 = 0xFF when x[6]=1 else 0x00 (64-pixel bars).
REQ-026 Y for pattern 2 = fill_y.
REQ-027 byte_out SHALL be 0x00 whenever href=0.
REQ-028 pattern_sel and fill_y SHALL be sampled at VSYNC entry and held constant for the frame.
REQ-029 after VFP: frame_done pulses 1 clk; next state VSYNC if enable=1, else IDLE.
REQ-030 enable deasserted mid-frame SHALL NOT truncate the frame; frame completes first.
REQ-031 x counter width 11 bits, y counter 10 bits; both wrap to 0 at line/frame end.

Reset
REQ-032 reset=1 SHALL force state IDLE, pclk=0, vsync=0, href=0, byte_out=0x00, frame_done=0, all counters and box position=0, within one clk, including mid-frame.
REQ-033 first VSYNC after reset release SHALL begin no earlier than 2 clks after enable=1 sampled.

Configuration
REQ-034 macro CAM_EMU_BOX_EN defined: pattern 3 SHALL output Y=0xFF inside a 16x16 box at (box_x, V_ACTIVE/2-8), fill_y elsewhere; box_x advances by 4 at each frame_done, wraps to 0 when box_x+16 > H_ACTIVE.
REQ-035 macro CAM_EMU_BOX_EN undefined: pattern 3 SHALL behave identically to pattern 2; no box logic synthesized.

Verification
REQ-036 H_ACTIVE=8,H_BLANK=2,V_ACTIVE=4,VSYNC_LINES=1,VBP_LINES=1,VFP_LINES=1, enable=1 -> per line 16 href-high slots then 4 low; frame_done every 7*20 pclk periods = 280 clks.
REQ-037 pattern 0, default params -> bytes at x=0..5 read 00,80,00,80,00,80,00,80,01,80,01,80 over first 12 slots... Y=x>>2 exactly; x=639 gives Y=0x9F.
REQ-038 pattern 2, fill_y=0x5A, fill_y changed to 0x11 mid-frame -> all even active bytes 0x5A until next frame, then 0x11.
REQ-039 enable dropped at line 2 of ACTIVE -> frame completes, frame_done pulses once, pclk stops at 0, outputs idle.
REQ-040 reset asserted mid-ACTIVE for 1 clk -> next clk all outputs 0, state IDLE; restart produces full VSYNC.
REQ-041 CAM_EMU_BOX_EN, pattern 3, default params, fill_y=0x10 -> frame 0 box at x 0..15 lines 232..247 Y=0xFF; frame 1 box at x 4..19; frame 157 box_x wraps to 0.

Source files
------------

// File: rtl/cam_emulator.sv
// cam_emulator: emulates a parallel camera sensor (OV76xx style) that emits
// a YUYV byte stream with pclk, vsync and href.
// Optional feature: define CAM_EMU_BOX_EN to enable the moving-box test
// pattern (pattern_sel = 3). Without it, pattern 3 outputs the solid fill.
//
// Timing model: the FSM and counters describe the byte slot that will be
// presented at the next falling edge of pclk. On that edge the outputs are
// loaded from a decode of the counters and the counters advance, so the
// outputs only ever change on the edge where pclk goes 1->0.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | stopped, pclk held low, all outputs 0
//   ST_VSYNC  | vsync lines (vsync=1)
//   ST_VBP    | vertical back porch, blank lines
//   ST_ACTIVE | active lines, href high for the active byte slots
//   ST_VFP    | vertical front porch, blank lines (also drains on stop)
module cam_emulator #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int VBP_LINES   = 17,
    parameter int VFP_LINES   = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    input  logic [7:0] fill_y,
    output logic       pclk,
    output logic       vsync,
    output logic       href,
    output logic [7:0] byte_out,
    output logic       frame_done
);

    localparam int LINE_SLOTS = 2 * (H_ACTIVE + H_BLANK);
    localparam int ACT_SLOTS  = 2 * H_ACTIVE;
`ifdef CAM_EMU_BOX_EN
    localparam int BOX_Y0     = V_ACTIVE / 2 - 8;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBP    = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFP    = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [10:0] x_cnt, x_nxt;
    logic [9:0]  y_cnt, y_nxt;
    logic        stop_pend, stop_nxt;
    logic        last_slot, last_nxt;
    logic        load_cfg;
    logic        frame_end;
    logic        tick;
    logic        line_end;
    logic        phase_end;
    logic [9:0]  phase_last;
    logic [1:0]  pat_q;
    logic [7:0]  fill_q;
    logic [7:0]  y_val;
    logic        vsync_nxt;
    logic        href_nxt;
    logic [7:0]  byte_nxt;

    // A tick is the clk edge on which pclk falls: one byte slot ends here.
    assign tick      = (state != ST_IDLE) && pclk;
    assign line_end  = (x_cnt == 11'(LINE_SLOTS - 1));
    assign phase_end = line_end && (y_cnt == phase_last);

    // Last line index of the current vertical phase.
    always_comb begin
        case (state)
            ST_VSYNC:  phase_last = 10'(VSYNC_LINES - 1);
            ST_VBP:    phase_last = 10'(VBP_LINES - 1);
            ST_ACTIVE: phase_last = 10'(V_ACTIVE - 1);
            default:   phase_last = 10'(VFP_LINES - 1);
        endcase
    end

    // State and counter register; pclk free-runs at clk/2 outside IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            x_cnt     <= '0;
            y_cnt     <= '0;
            stop_pend <= 1'b0;
            last_slot <= 1'b0;
            pclk      <= 1'b0;
        end else begin
            state     <= state_nxt;
            x_cnt     <= x_nxt;
            y_cnt     <= y_nxt;
            stop_pend <= stop_nxt;
            last_slot <= last_nxt;
            pclk      <= (state != ST_IDLE) ? ~pclk : 1'b0;
        end
    end

    // Next-state logic. The end-of-frame decision is taken while the last
    // VFP slot is being presented; with enable low the FSM waits one more
    // slot (stop_pend) so the last slot still gets its full pclk period.
    always_comb begin
        state_nxt = state;
        x_nxt     = x_cnt;
        y_nxt     = y_cnt;
        stop_nxt  = stop_pend;
        last_nxt  = last_slot;
        load_cfg  = 1'b0;
        frame_end = 1'b0;
        if (state == ST_IDLE) begin
            if (enable) begin
                state_nxt = ST_VSYNC;
                x_nxt     = '0;
                y_nxt     = '0;
                stop_nxt  = 1'b0;
                last_nxt  = 1'b0;
                load_cfg  = 1'b1;
            end
        end else if (tick) begin
            frame_end = last_slot;
            last_nxt  = 1'b0;
            if (stop_pend) begin
                state_nxt = ST_IDLE;
                stop_nxt  = 1'b0;
                x_nxt     = '0;
                y_nxt     = '0;
            end else if (!line_end) begin
                x_nxt = x_cnt + 11'd1;
            end else begin
                x_nxt = '0;
                if (!phase_end) begin
                    y_nxt = y_cnt + 10'd1;
                end else begin
                    y_nxt = '0;
                    case (state)
                        ST_VSYNC:  state_nxt = ST_VBP;
                        ST_VBP:    state_nxt = ST_ACTIVE;
                        ST_ACTIVE: state_nxt = ST_VFP;
                        default: begin
                            last_nxt = 1'b1;
                            if (enable) begin
                                state_nxt = ST_VSYNC;
                                load_cfg  = 1'b1;
                            end else begin
                                stop_nxt = 1'b1;
                            end
                        end
                    endcase
                end
            end
        end
    end

    // Pattern configuration is frozen for the whole frame at VSYNC entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q  <= 2'd0;
            fill_q <= 8'h00;
        end else if (load_cfg) begin
            pat_q  <= pattern_sel;
            fill_q <= fill_y;
        end
    end

`ifdef CAM_EMU_BOX_EN
    logic [10:0] box_x;
    logic [10:0] pix_x;
    logic        in_box;

    assign pix_x  = {1'b0, x_cnt[10:1]};
    assign in_box = (pix_x >= box_x) && (pix_x < box_x + 11'd16) &&
                    (int'(y_cnt) >= BOX_Y0) && (int'(y_cnt) < BOX_Y0 + 16);

    // Box steps right by 4 pixels per frame and wraps when it would clip.
    always_ff @(posedge clk) begin
        if (reset) begin
            box_x <= '0;
        end else if (frame_end) begin
            if (int'(box_x) + 4 + 16 > H_ACTIVE)
                box_x <= '0;
            else
                box_x <= box_x + 11'd4;
        end
    end
`endif

    // Output decode for the slot about to be presented (slot = 2*x + odd).
    always_comb begin
        case (pat_q)
            2'd0:    y_val = x_cnt[10:3];
            2'd1:    y_val = x_cnt[7] ? 8'hFF : 8'h00;
`ifdef CAM_EMU_BOX_EN
            2'd3:    y_val = in_box ? 8'hFF : fill_q;
`endif
            default: y_val = fill_q;
        endcase
        vsync_nxt = (state == ST_VSYNC);
        href_nxt  = (state == ST_ACTIVE) && (x_cnt < 11'(ACT_SLOTS));
        byte_nxt  = 8'h00;
        if (href_nxt)
            byte_nxt = x_cnt[0] ? 8'h80 : y_val;
    end

    // Output registers load only on pclk falling edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            vsync      <= 1'b0;
            href       <= 1'b0;
            byte_out   <= 8'h00;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (tick) begin
                vsync    <= vsync_nxt;
                href     <= href_nxt;
                byte_out <= byte_nxt;
            end
        end
    end

endmodule

// File: tb/tb_cam_emulator.sv
// Testbench for cam_emulator: a small-geometry instance for frame-level
// behaviour and a full-width, short-frame instance for the pixel patterns.
module tb_cam_emulator;

    localparam int SH_A = 8, SH_B = 2, SV_A = 4, S_VS = 1, S_VBP = 1, S_VFP = 1;
    localparam int S_LS = 2 * (SH_A + SH_B);
    localparam int S_FS = S_LS * (S_VS + S_VBP + SV_A + S_VFP);
    localparam int WH_A = 640, WH_B = 4, WV_A = 1, W_VS = 1, W_VBP = 1, W_VFP = 1;
    localparam int W_LS = 2 * (WH_A + WH_B);
    localparam int W_FS = W_LS * (W_VS + W_VBP + WV_A + W_VFP);

    logic       clk;
    logic       reset;
    logic       s_en, w_en;
    logic [1:0] s_pat, w_pat;
    logic [7:0] s_fill, w_fill;
    logic       s_pclk, s_vs, s_href, s_fd;
    logic       w_pclk, w_vs, w_href, w_fd;
    logic [7:0] s_byte, w_byte;
    logic       s_pclk_d, w_pclk_d;
    int         cyc;
    int         s_fd_cnt;
    int         s_bx;
    int         total, bad;
    logic [7:0] ramp_lit [12];

    cam_emulator #(
        .H_ACTIVE(SH_A), .V_ACTIVE(SV_A), .H_BLANK(SH_B),
        .VSYNC_LINES(S_VS), .VBP_LINES(S_VBP), .VFP_LINES(S_VFP)
    ) dut_s (
        .clk(clk), .reset(reset), .enable(s_en), .pattern_sel(s_pat),
        .fill_y(s_fill), .pclk(s_pclk), .vsync(s_vs), .href(s_href),
        .byte_out(s_byte), .frame_done(s_fd)
    );

    cam_emulator #(
        .H_ACTIVE(WH_A), .V_ACTIVE(WV_A), .H_BLANK(WH_B),
        .VSYNC_LINES(W_VS), .VBP_LINES(W_VBP), .VFP_LINES(W_VFP)
    ) dut_w (
        .clk(clk), .reset(reset), .enable(w_en), .pattern_sel(w_pat),
        .fill_y(w_fill), .pclk(w_pclk), .vsync(w_vs), .href(w_href),
        .byte_out(w_byte), .frame_done(w_fd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        s_fd_cnt = 0;
    end

    // pclk as it was before the latest rising clk edge, for slot detection
    always @(posedge clk) begin
        s_pclk_d <= s_pclk;
        w_pclk_d <= w_pclk;
        cyc      <= cyc + 1;
        if (s_fd) s_fd_cnt <= s_fd_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Reference: {vsync, href, byte} for slot fs of a frame, from geometry.
    function automatic logic [9:0] exp_slot(input int fs, input int ha, input int hb,
                                            input int va, input int nvs, input int nvbp,
                                            input int pat, input int fill, input int boxx);
        int ls, ln, s, al, px, y;
        logic [9:0] r;
        ls = 2 * (ha + hb);
        ln = fs / ls;
        s  = fs % ls;
        al = ln - nvs - nvbp;
        r  = '0;
        if (ln < nvs) r[9] = 1'b1;
        if (al >= 0 && al < va && s < 2 * ha) begin
            r[8] = 1'b1;
            px = s / 2;
            case (pat)
                0:       y = (px / 4) % 256;
                1:       y = ((px / 64) % 2 == 1) ? 255 : 0;
                default: y = fill;
            endcase
`ifdef CAM_EMU_BOX_EN
            if (pat == 3 && px >= boxx && px < boxx + 16 &&
                al >= va / 2 - 8 && al < va / 2 + 8)
                y = 255;
`endif
            r[7:0] = (s % 2 == 1) ? 8'h80 : 8'(y);
        end
        return r;
    endfunction

    task automatic wait_slot(input bit wide, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if (wide ? (w_pclk_d && !w_pclk) : (s_pclk_d && !s_pclk)) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({s_pclk, s_vs, s_href, s_byte, s_fd} !== 12'h000) begin
            bad++;
            $display("FAIL reset_small: got %h want 000", {s_pclk, s_vs, s_href, s_byte, s_fd});
        end
        total++;
        if ({w_pclk, w_vs, w_href, w_byte, w_fd} !== 12'h000) begin
            bad++;
            $display("FAIL reset_wide: got %h want 000", {w_pclk, w_vs, w_href, w_byte, w_fd});
        end
        reset = 1'b0;
        s_bx = 0;
        repeat (6) @(negedge clk);
        total++;
        if ({s_pclk, s_vs, s_fd} !== 3'b000) begin
            bad++;
            $display("FAIL idle_hold: pclk/vsync/fd got %b want 000", {s_pclk, s_vs, s_fd});
        end
    endtask

    task automatic test_frames(input int nframes, input logic [1:0] pat0, input logic [7:0] fill0);
        int cur_pat, cur_fill, nxt_pat, nxt_fill, n, fd0, t0;
        bit ok, got;
        logic [9:0] e;
        s_pat = pat0;
        s_fill = fill0;
        cur_pat = int'(pat0);
        cur_fill = int'(fill0);
        nxt_pat = cur_pat;
        nxt_fill = cur_fill;
        fd0 = s_fd_cnt;
        @(negedge clk);
        s_en = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (s_pclk_d && !s_pclk) got = 1'b1;
        end
        total++;
        if (!got || n < 3) begin
            bad++;
            $display("FAIL start_latency: got %0d clks (seen=%0d) want >=3", n, got);
            if (!got) begin s_en = 1'b0; return; end
        end
        t0 = cyc;
        for (int f = 0; f < nframes; f++) begin
            for (int fs = 0; fs < S_FS; fs++) begin
                if (f != 0 || fs != 0) begin
                    wait_slot(1'b0, ok);
                    if (!ok) begin
                        total++; bad++;
                        $display("FAIL slot_timeout: frame %0d slot %0d", f, fs);
                        s_en = 1'b0;
                        return;
                    end
                end
                e = exp_slot(fs, SH_A, SH_B, SV_A, S_VS, S_VBP, cur_pat, cur_fill, s_bx);
                total++;
                if ({s_vs, s_href, s_byte} !== e) begin
                    bad++;
                    $display("FAIL stream: frame %0d slot %0d got %h want %h", f, fs, {s_vs, s_href, s_byte}, e);
                end
                total++;
                if (s_fd !== (f > 0 && fs == 0)) begin
                    bad++;
                    $display("FAIL frame_done: frame %0d slot %0d got %b want %b", f, fs, s_fd, (f > 0 && fs == 0));
                end
                if (fs == 0 && f > 0) begin
                    total++;
                    if (cyc - t0 != 2 * S_FS) begin
                        bad++;
                        $display("FAIL frame_period: got %0d clks want %0d", cyc - t0, 2 * S_FS);
                    end
                    t0 = cyc;
                end
                if (fs == 3 * S_LS + 5) begin
                    nxt_pat = int'($urandom_range(0, 3));
                    nxt_fill = int'($urandom_range(0, 255));
                    s_pat = 2'(nxt_pat);
                    s_fill = 8'(nxt_fill);
                end
                if (f == nframes - 1 && fs == (S_VS + S_VBP + 2) * S_LS)
                    s_en = 1'b0;
            end
            cur_pat = nxt_pat;
            cur_fill = nxt_fill;
            s_bx = (s_bx + 4 + 16 > SH_A) ? 0 : s_bx + 4;
        end
        wait_slot(1'b0, ok);
        total++;
        if (!ok || {s_vs, s_href, s_byte, s_fd} !== 11'h001) begin
            bad++;
            $display("FAIL frame_end: seen=%0d got %h want 001", ok, {s_vs, s_href, s_byte, s_fd});
        end
        repeat (6) @(negedge clk);
        total++;
        if ({s_pclk, s_vs, s_href, s_byte} !== 11'h000) begin
            bad++;
            $display("FAIL stopped: got %h want 000", {s_pclk, s_vs, s_href, s_byte});
        end
        total++;
        if (s_fd_cnt - fd0 != nframes) begin
            bad++;
            $display("FAIL fd_count: got %0d want %0d", s_fd_cnt - fd0, nframes);
        end
    endtask

    task automatic test_reset_mid;
        int n, cnt;
        bit ok, got, done;
        s_pat = 2'd0;
        @(negedge clk);
        s_en = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (s_href) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL reach_active: href never rose");
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({s_pclk, s_vs, s_href, s_byte, s_fd} !== 12'h000) begin
            bad++;
            $display("FAIL reset_mid: got %h want 000", {s_pclk, s_vs, s_href, s_byte, s_fd});
        end
        reset = 1'b0;
        s_bx = 0;
        n = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (s_vs) got = 1'b1;
        end
        total++;
        if (!got || n < 3) begin
            bad++;
            $display("FAIL restart_latency: got %0d clks (seen=%0d) want >=3", n, got);
        end
        cnt = 1;
        done = 1'b0;
        for (int i = 0; i < 3 * S_LS && !done; i++) begin
            wait_slot(1'b0, ok);
            if (ok && s_vs) cnt++;
            else done = 1'b1;
        end
        total++;
        if (cnt != S_LS * S_VS) begin
            bad++;
            $display("FAIL vsync_len: got %0d slots want %0d", cnt, S_LS * S_VS);
        end
        s_en = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 600 && !got; i++) begin
            @(negedge clk);
            if (s_fd) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL restart_frame_done: no pulse seen");
        end
        s_bx = (s_bx + 4 + 16 > SH_A) ? 0 : s_bx + 4;
        repeat (3) @(negedge clk);
        total++;
        if ({s_pclk, s_vs, s_href} !== 3'b000) begin
            bad++;
            $display("FAIL restart_idle: got %b want 000", {s_pclk, s_vs, s_href});
        end
    endtask

    task automatic test_wide_line(input logic [1:0] pat);
        int fill, base;
        bit ok, got;
        logic [9:0] e;
        fill = int'($urandom_range(0, 255));
        w_pat = pat;
        w_fill = 8'(fill);
        base = (W_VS + W_VBP) * W_LS;
        @(negedge clk);
        w_en = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (w_pclk_d && !w_pclk) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL wide_start: no first slot");
            w_en = 1'b0;
            return;
        end
        for (int fs = 0; fs < W_FS; fs++) begin
            if (fs != 0) begin
                wait_slot(1'b1, ok);
                if (!ok) begin
                    total++; bad++;
                    $display("FAIL wide_timeout: slot %0d", fs);
                    w_en = 1'b0;
                    return;
                end
            end
            e = exp_slot(fs, WH_A, WH_B, WV_A, W_VS, W_VBP, int'(pat), fill, 0);
            total++;
            if ({w_vs, w_href, w_byte} !== e) begin
                bad++;
                $display("FAIL wide_stream: pat %0d slot %0d got %h want %h", pat, fs, {w_vs, w_href, w_byte}, e);
            end
            if (pat == 2'd0 && fs >= base && fs < base + 12) begin
                total++;
                if (w_byte !== ramp_lit[fs - base]) begin
                    bad++;
                    $display("FAIL ramp_start: slot %0d got %h want %h", fs - base, w_byte, ramp_lit[fs - base]);
                end
            end
            if (pat == 2'd0 && fs == base + 2 * 639) begin
                total++;
                if (w_byte !== 8'h9F) begin
                    bad++;
                    $display("FAIL ramp_x639: got %h want 9f", w_byte);
                end
            end
            if (fs == 0) w_en = 1'b0;
        end
        wait_slot(1'b1, ok);
        total++;
        if (!ok || {w_vs, w_href, w_byte, w_fd} !== 11'h001) begin
            bad++;
            $display("FAIL wide_end: seen=%0d got %h want 001", ok, {w_vs, w_href, w_byte, w_fd});
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        ramp_lit = '{8'h00, 8'h80, 8'h00, 8'h80, 8'h00, 8'h80,
                     8'h00, 8'h80, 8'h01, 8'h80, 8'h01, 8'h80};
        reset = 1'b1;
        s_en = 1'b0;
        w_en = 1'b0;
        s_pat = 2'd0;
        w_pat = 2'd0;
        s_fill = 8'h00;
        w_fill = 8'h00;
        s_bx = 0;
        test_reset;
        test_frames(1, 2'd2, 8'h5A);
        test_frames(3, 2'd2, 8'h5A);
        test_frames(3, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        test_frames(2, 2'd3, 8'h10);
        test_reset_mid;
        test_wide_line(2'd0);
        test_wide_line(2'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
